// File: rtl/seg_bus_decoder_pkg.sv
// ============================================================================
// Module  : seg_pkg
// Brief   : Segment code table, bus field positions and decoder FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seg_pkg;

    // Segment patterns listed G..A, i.e. bus bits [6:0]
    localparam logic [6:0] SEG_CODE [0:7] = '{
        7'b1111111, 7'b0001000, 7'b1000110, 7'b1000111,
        7'b0010010, 7'b0000001, 7'b1000010, 7'b0000110
    };

    localparam int unsigned SEG_H_BIT  = 7;
    localparam int unsigned SEG_I_BIT  = 8;
    localparam int unsigned SEG_EN_LSB = 9;
    localparam int unsigned SEG_EN_MSB = 11;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        EVAL   = 2'd1,
        LOCKED = 2'd2
    } segState_t;

endpackage

`default_nettype wire

// File: rtl/seg_bus_decoder_if.sv
// ============================================================================
// Module  : seg_bus_decoder_if
// Brief   : Segment bus input and per-digit status outputs of the decoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface seg_bus_decoder_if;
    logic [11:0] segs_in;
    logic [8:0]  code;
    logic [2:0]  code_valid;
    logic [2:0]  code_err;
    logic        upd;
    logic [1:0]  upd_digit;
    logic        frame_err;

    modport master (
        output segs_in,
        input  code, code_valid, code_err, upd, upd_digit, frame_err
    );

    modport slave (
        input  segs_in,
        output code, code_valid, code_err, upd, upd_digit, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/seg_bus_decoder_decode.sv
// ============================================================================
// Module  : seg_pattern_decode
// Brief   : Inverse of the encoder segment table: pattern -> code plus hit flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_pattern_decode
    import seg_pkg::*;
(
    input  wire logic [6:0] i_seg,
    output logic      [2:0] o_code,
    output logic            o_hit
);

    always_comb begin
        o_code = 3'd0;
        o_hit  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i_seg == SEG_CODE[i]) begin
                o_code = 3'(i);
                o_hit  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_bus_decoder.sv
// ============================================================================
// Module  : seg_bus_decoder
// Brief   : Samples the multiplexed segment bus and recovers per-digit codes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_bus_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    seg_bus_decoder_if.slave bus
);

    localparam logic [7:0] c_stable   = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_stableM1 = 8'(STABLE_CYCLES - 1);

    logic [11:0] r_meta;
    logic [11:0] r_sync;
    logic [11:0] r_prev;
    logic [7:0]  r_cnt;
    segState_t   r_state;
    segState_t   w_nextState;
    logic        w_same;

    logic [2:0]  w_en;
    logic [2:0]  w_decCode;
    logic        w_decHit;
    logic        w_legal;
    logic [1:0]  w_digit;
    logic        w_oneHot;
    logic        w_updNext;
    logic        w_frameErrNext;

    logic [8:0]  r_code;
    logic [2:0]  r_codeValid;
    logic [2:0]  r_codeErr;
    logic        r_upd;
    logic [1:0]  r_updDigit;
    logic        r_frameErr;

    assign w_same = (r_sync == r_prev);

    // Reset to all-ones so every enable reads inactive until the bus is seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '1;
            r_sync <= '1;
            r_prev <= '1;
        end else begin
            r_meta <= bus.segs_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (!w_same) begin
            r_cnt <= 8'd0;
        end else if (r_cnt < c_stable) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SETTLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            SETTLE: if (w_same && (r_cnt == c_stableM1)) w_nextState = EVAL;
            // A change landing during evaluation still gets its own window
            EVAL:   w_nextState = w_same ? LOCKED : SETTLE;
            LOCKED: if (!w_same) w_nextState = SETTLE;
            default: w_nextState = SETTLE;
        endcase
    end

    // In EVAL, prev always holds the frame that proved stable
    assign w_en = ~r_prev[SEG_EN_MSB:SEG_EN_LSB];

    seg_pattern_decode u_decode (
        .i_seg  (r_prev[6:0]),
        .o_code (w_decCode),
        .o_hit  (w_decHit)
    );

    always_comb begin
        w_digit  = 2'd0;
        w_oneHot = 1'b0;
        case (w_en)
            3'b001: begin w_digit = 2'd0; w_oneHot = 1'b1; end
            3'b010: begin w_digit = 2'd1; w_oneHot = 1'b1; end
            3'b100: begin w_digit = 2'd2; w_oneHot = 1'b1; end
            default: begin w_digit = 2'd0; w_oneHot = 1'b0; end
        endcase
        w_legal        = w_decHit && r_prev[SEG_I_BIT] && !r_prev[SEG_H_BIT];
        w_updNext      = (r_state == EVAL) && w_oneHot;
        w_frameErrNext = (r_state == EVAL) && ($countones(w_en) > 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code      <= 9'd0;
            r_codeValid <= 3'd0;
            r_codeErr   <= 3'd0;
            r_upd       <= 1'b0;
            r_updDigit  <= 2'd0;
            r_frameErr  <= 1'b0;
        end else begin
            r_upd      <= w_updNext;
            r_frameErr <= w_frameErrNext;
            if (w_updNext) begin
                r_updDigit <= w_digit;
                for (int d = 0; d < 3; d++) begin
                    if (w_digit == 2'(d)) begin
                        r_codeValid[d] <= w_legal;
                        r_codeErr[d]   <= !w_legal;
                        if (w_legal) r_code[3*d +: 3] <= w_decCode;
                    end
                end
            end
        end
    end

    assign bus.code       = r_code;
    assign bus.code_valid = r_codeValid;
    assign bus.code_err   = r_codeErr;
    assign bus.upd        = r_upd;
    assign bus.upd_digit  = r_updDigit;
    assign bus.frame_err  = r_frameErr;

endmodule

`default_nettype wire

// File: tb/tb_seg_bus_decoder.sv
// ============================================================================
// Module  : tb_seg_bus_decoder
// Brief   : Directed self-checking bench for seg_bus_decoder (STABLE_CYCLES=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg_bus_decoder;

    logic clk = 1'b0;
    logic reset;

    int nCompared   = 0;
    int nMismatched = 0;

    int updCount      = 0;
    int frameErrCount = 0;
    int bothHigh      = 0;
    int longPulse     = 0;
    logic prevUpd     = 1'b0;
    logic prevFerr    = 1'b0;
    int stepIdx       = 0;
    int firstUpdStep  = 0;
    logic [1:0] firstUpdDigit = 2'd0;

    int updBase;
    int ferrBase;

    always #5 clk = ~clk;

    seg_bus_decoder_if bus ();

    seg_bus_decoder #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic startWindow();
        stepIdx      = 0;
        firstUpdStep = 0;
    endtask

    // Advance n edges, sampling 1 ns after each rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            stepIdx++;
            if (bus.upd) begin
                updCount++;
                if (firstUpdStep == 0) begin
                    firstUpdStep  = stepIdx;
                    firstUpdDigit = bus.upd_digit;
                end
            end
            if (bus.frame_err) frameErrCount++;
            if (bus.upd && bus.frame_err) bothHigh++;
            if ((bus.upd && prevUpd) || (bus.frame_err && prevFerr)) longPulse++;
            prevUpd  = bus.upd;
            prevFerr = bus.frame_err;
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.segs_in = 12'hFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_code",      32'(bus.code),       32'h0);
        check("rst_valid",     32'(bus.code_valid), 32'h0);
        check("rst_err",       32'(bus.code_err),   32'h0);
        check("rst_upd",       32'(bus.upd),        32'h0);
        check("rst_updDigit",  32'(bus.upd_digit),  32'h0);
        check("rst_frameErr",  32'(bus.frame_err),  32'h0);
        reset = 1'b0;
        tick(3);

        // Digit 0, code 1, legal point bits; upd expected 7 edges after the hold edge
        bus.segs_in = 12'b110_10_0001000;
        startWindow();
        updBase = updCount;
        tick(10);
        check("lat_firstUpdStep", 32'(firstUpdStep),  32'd8);
        check("lat_updDigit",     32'(firstUpdDigit), 32'd0);
        check("lat_code0",        32'(bus.code[2:0]), 32'd1);
        check("lat_valid",        32'(bus.code_valid), 32'b001);
        tick(10);
        check("lat_noRepeat",     32'(updCount - updBase), 32'd1);

        // Scan digits 0/1/2 with codes 5/2/7
        updBase = updCount;
        bus.segs_in = 12'b110_10_0000001; tick(10);
        bus.segs_in = 12'b101_10_1000110; tick(10);
        bus.segs_in = 12'b011_10_0000110; tick(10);
        check("scan_updCount", 32'(updCount - updBase), 32'd3);
        check("scan_code",     32'(bus.code),       32'({3'd7, 3'd2, 3'd5}));
        check("scan_valid",    32'(bus.code_valid), 32'b111);
        check("scan_err",      32'(bus.code_err),   32'b000);

        // Digit 1 with an unknown pattern
        updBase = updCount;
        startWindow();
        bus.segs_in = 12'b101_10_1010101; tick(10);
        check("ill_updCount", 32'(updCount - updBase), 32'd1);
        check("ill_updDigit", 32'(firstUpdDigit),    32'd1);
        check("ill_err",      32'(bus.code_err),     32'b010);
        check("ill_valid",    32'(bus.code_valid),   32'b101);
        check("ill_code",     32'(bus.code),         32'({3'd7, 3'd2, 3'd5}));

        // Two enables low
        updBase  = updCount;
        ferrBase = frameErrCount;
        bus.segs_in = 12'b100_10_0001000; tick(10);
        check("fe_count",   32'(frameErrCount - ferrBase), 32'd1);
        check("fe_noUpd",   32'(updCount - updBase),       32'd0);
        check("fe_code",    32'(bus.code),       32'({3'd7, 3'd2, 3'd5}));
        check("fe_valid",   32'(bus.code_valid), 32'b101);
        check("fe_err",     32'(bus.code_err),   32'b010);

        // Lock digit 0 on code 3, then a 3-cycle glitch that would read as code 2
        bus.segs_in = 12'b110_10_1000111; tick(12);
        check("gl_lockCode", 32'(bus.code[2:0]), 32'd3);
        updBase = updCount;
        bus.segs_in = 12'b110_10_1000110; tick(3);
        bus.segs_in = 12'b110_10_1000111; tick(6);
        check("gl_noUpd",  32'(updCount - updBase), 32'd0);
        tick(6);
        check("gl_code",   32'(bus.code[2:0]),  32'd3);
        check("gl_valid0", 32'(bus.code_valid[0]), 32'd1);
        updBase = updCount;
        bus.segs_in = 12'b110_10_1000110; tick(10);
        check("chg_oneUpd", 32'(updCount - updBase), 32'd1);
        check("chg_code",   32'(bus.code[2:0]),      32'd2);

        // Reset while settling on digit 2, code 4
        bus.segs_in = 12'b011_10_0010010; tick(3);
        reset = 1'b1;
        #1;
        check("mid_code",  32'(bus.code),       32'h0);
        check("mid_valid", 32'(bus.code_valid), 32'h0);
        check("mid_err",   32'(bus.code_err),   32'h0);
        check("mid_upd",   32'(bus.upd),        32'h0);
        check("mid_ferr",  32'(bus.frame_err),  32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        prevUpd = 1'b0;
        prevFerr = 1'b0;
        startWindow();
        tick(12);
        check("rel_firstUpdStep", 32'(firstUpdStep),  32'd8);
        check("rel_updDigit",     32'(firstUpdDigit), 32'd2);
        check("rel_code",         32'(bus.code),      32'({3'd4, 3'd0, 3'd0}));
        check("rel_valid",        32'(bus.code_valid), 32'b100);

        check("pulse_exclusive", 32'(bothHigh),  32'd0);
        check("pulse_single",    32'(longPulse), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

`default_nettype wire
